// File: rtl/fpu_int_to_float.sv
// Converts a signed two's-complement integer into the FPU's {sign, exp, fraction} float format.
// Normalisation shifts the magnitude left by one bit per cycle. Only one conversion is in flight at a time.
module fpu_int_to_float #(
  parameter int INT_W = 32,
  parameter int EXP_W = 6,
  parameter int MAN_W = 25,
  parameter int BIAS  = 31
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INT_W-1:0]             int_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [1+EXP_W+MAN_W-1:0]     fp_out,
  output logic [3:0]                   status_out
);

  localparam int FP_W   = 1 + EXP_W + MAN_W;
  localparam int DROP_W = INT_W - 1 - MAN_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    PACK = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [INT_W-1:0]  mag_q, mag_d;
  logic [EXP_W-1:0]  exp_cnt_q, exp_cnt_d;
  logic              sign_q, sign_d;
  logic              out_valid_q, out_valid_d;
  logic [FP_W-1:0]   fp_q, fp_d;
  logic [3:0]        status_q, status_d;

  logic [EXP_W-1:0]  biased_exp;
  logic [MAN_W-1:0]  fraction;
  logic              inexact;

  // The normalised magnitude carries its leading 1 in the MSB; the fraction is the bits just below it.
  assign biased_exp = exp_cnt_q + EXP_W'(BIAS);
  assign fraction   = mag_q[INT_W-2 -: MAN_W];
  assign inexact    = |mag_q[DROP_W-1:0];

  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    exp_cnt_d   = exp_cnt_q;
    sign_d      = sign_q;
    out_valid_d = out_valid_q;
    fp_d        = fp_q;
    status_d    = status_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d    = int_in[INT_W-1];
          mag_d     = int_in[INT_W-1] ? (~int_in + INT_W'(1)) : int_in;
          exp_cnt_d = EXP_W'(INT_W - 1);
          state_d   = (int_in == '0) ? PACK : NORM;
        end
      end
      NORM: begin
        if (mag_q[INT_W-1]) begin
          state_d = PACK;
        end else begin
          mag_d     = mag_q << 1;
          exp_cnt_d = exp_cnt_q - EXP_W'(1);
        end
      end
      PACK: begin
        if (mag_q == '0) begin
          fp_d     = '0;
          status_d = 4'b0001;
        end else begin
          fp_d     = {sign_q, biased_exp, fraction};
          status_d = {1'b0, sign_q, inexact, 1'b0};
        end
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      exp_cnt_q   <= '0;
      sign_q      <= 1'b0;
      out_valid_q <= 1'b0;
      fp_q        <= '0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      exp_cnt_q   <= exp_cnt_d;
      sign_q      <= sign_d;
      out_valid_q <= out_valid_d;
      fp_q        <= fp_d;
      status_q    <= status_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = out_valid_q;
  assign fp_out     = fp_q;
  assign status_out = status_q;

endmodule

// File: tb/tb_fpu_int_to_float.sv
// Self-checking bench for fpu_int_to_float: directed vector table, backpressure and reset
// sequences, and a randomised run against a reference model.
module tb_fpu_int_to_float;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] int_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] fp_out;
  logic [3:0]  status_out;

  int checks = 0;
  int errors = 0;

  fpu_int_to_float dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .int_in     (int_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fp_out     (fp_out),
    .status_out (status_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] val;
    logic [31:0] fp;
    logic [3:0]  st;
    int          lat;
  } vec_t;

  vec_t vecs [9];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Independent model: locate the MSB, normalise, truncate.
  task automatic refModel(input logic [31:0] v, output logic [31:0] fp,
                          output logic [3:0] st, output int lat);
    logic        s;
    logic [31:0] m;
    logic [31:0] n;
    int          p;
    if (v == 32'h0) begin
      fp = 32'h0; st = 4'b0001; lat = 1;
    end else begin
      s = v[31];
      m = s ? (32'h0 - v) : v;
      p = 31;
      while (m[p] == 1'b0) p--;
      n   = m << (31 - p);
      fp  = {s, 6'(p + 31), n[30:6]};
      st  = {1'b0, s, |n[5:0], 1'b0};
      lat = (31 - p) + 2;
    end
  endtask

  // Wait for out_valid after the accept edge; lat counts edges after E0.
  task automatic waitOutput(output int lat);
    lat = 0;
    while (lat < 40) begin
      @(posedge clock); #1;
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) begin
      errors++;
      checks++;
      $display("[TB] FAIL timeout: out_valid not seen after %0d cycles", lat);
      lat = -1;
    end
  endtask

  // Drive one value, accept it at E0 and wait for the result.
  task automatic applyStimulus(input logic [31:0] v, output int lat);
    int_in   = v;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    waitOutput(lat);
  endtask

  task automatic doHandshake(input int stall, input logic [31:0] fp_exp);
    for (int i = 0; i < stall; i++) begin
      @(posedge clock); #1;
      checkOutput("stall_fp", fp_out, fp_exp);
      checkOutput("stall_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    checkOutput("hs_valid_low", 32'(out_valid), 32'd0);
    checkOutput("hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic convertAndCheck(input string name, input logic [31:0] v, input logic [31:0] fp_exp,
                                 input logic [3:0] st_exp, input int lat_exp, input int stall);
    int lat;
    applyStimulus(v, lat);
    checkOutput({name, "_fp"}, fp_out, fp_exp);
    checkOutput({name, "_status"}, 32'(status_out), 32'(st_exp));
    checkOutput({name, "_latency"}, 32'(lat), 32'(lat_exp));
    if (lat >= 0) doHandshake(stall, fp_exp);
    else begin
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
    end
  endtask

  initial begin
    int          lat;
    logic [31:0] v;
    logic [31:0] fp_e;
    logic [3:0]  st_e;
    int          lat_e;

    vecs[0] = '{32'h00000001, 32'h3E000000, 4'b0000, 33};
    vecs[1] = '{32'hFFFFFFFA, 32'hC3000000, 4'b0100, 31};
    vecs[2] = '{32'h00000000, 32'h00000000, 4'b0001, 1};
    vecs[3] = '{32'h80000000, 32'hFC000000, 4'b0100, 2};
    vecs[4] = '{32'h7FFFFFFF, 32'h7BFFFFFF, 4'b0010, 3};
    vecs[5] = '{32'h00000003, 32'h41000000, 4'b0000, 32};
    vecs[6] = '{32'h00000002, 32'h40000000, 4'b0000, 32};
    vecs[7] = '{32'hFFFFFFFF, 32'hBE000000, 4'b0100, 33};
    vecs[8] = '{32'h00000040, 32'h4A000000, 4'b0000, 27};

    reset = 1'b1; in_valid = 1'b0; int_in = '0; out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_fp", fp_out, 32'h0);
    checkOutput("reset_status", 32'(status_out), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 9; i++)
      convertAndCheck($sformatf("vec%0d", i), vecs[i].val, vecs[i].fp, vecs[i].st, vecs[i].lat, 0);

    // Backpressure: result held, new input ignored, next input taken the cycle after handshake.
    applyStimulus(32'd5, lat);
    checkOutput("bp_fp", fp_out, 32'h42800000);
    checkOutput("bp_latency", 32'(lat), 32'd31);
    int_in   = 32'd7;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      checkOutput("bp_hold_fp", fp_out, 32'h42800000);
      checkOutput("bp_hold_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
    checkOutput("bp_release_valid", 32'(out_valid), 32'd0);
    checkOutput("bp_release_fp_held", fp_out, 32'h42800000);
    @(posedge clock); #1;
    in_valid = 1'b0;
    checkOutput("bp_next_accepted", 32'(in_ready), 32'd0);
    waitOutput(lat);
    checkOutput("bp_next_fp", fp_out, 32'h43800000);
    checkOutput("bp_next_latency", 32'(lat), 32'd31);
    doHandshake(0, 32'h43800000);

    // Reset in the middle of normalisation.
    int_in   = 32'd1;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    checkOutput("mid_in_ready_busy", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checkOutput("mid_reset_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_reset_fp", fp_out, 32'h0);
    checkOutput("mid_reset_in_ready", 32'(in_ready), 32'd1);
    convertAndCheck("after_reset", 32'd3, 32'h41000000, 4'b0000, 32, 0);

    // Powers of two of both signs, then random values with random consumer stalls.
    for (int k = 0; k < 32; k++) begin
      v = 32'h1 << k;
      refModel(v, fp_e, st_e, lat_e);
      convertAndCheck("pow2", v, fp_e, st_e, lat_e, 0);
      v = 32'h0 - v;
      refModel(v, fp_e, st_e, lat_e);
      convertAndCheck("neg_pow2", v, fp_e, st_e, lat_e, k % 3);
    end
    for (int n = 0; n < 300; n++) begin
      v = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = 32'h0 - v;
      refModel(v, fp_e, st_e, lat_e);
      convertAndCheck("random", v, fp_e, st_e, lat_e, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
